// File: rtl/fetch_control_pkg.sv
// Shared definitions for the fetch/control sequencer: field widths, opcodes,
// write-data and ALU encodings, FSM states and the decoded control bundle.
package fetch_control_pkg;

  localparam int unsigned INSTR_W   = 16;
  localparam int unsigned OPC_W     = 4;
  localparam int unsigned REG_SEL_W = 4;
  localparam int unsigned IMM_W     = 8;
  localparam int unsigned WSEL_W    = 2;
  localparam int unsigned ALU_OP_W  = 2;

  localparam logic [OPC_W-1:0] OP_NOP = 4'h0;
  localparam logic [OPC_W-1:0] OP_LDI = 4'h1;
  localparam logic [OPC_W-1:0] OP_MOV = 4'h2;
  localparam logic [OPC_W-1:0] OP_ADD = 4'h3;
  localparam logic [OPC_W-1:0] OP_SUB = 4'h4;
  localparam logic [OPC_W-1:0] OP_INC = 4'h5;
  localparam logic [OPC_W-1:0] OP_DEC = 4'h6;
  localparam logic [OPC_W-1:0] OP_JMP = 4'h7;
  localparam logic [OPC_W-1:0] OP_BRZ = 4'h8;
  localparam logic [OPC_W-1:0] OP_HLT = 4'hF;

  localparam logic [WSEL_W-1:0] WSEL_IMM = 2'd0;
  localparam logic [WSEL_W-1:0] WSEL_B   = 2'd1;
  localparam logic [WSEL_W-1:0] WSEL_ALU = 2'd2;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = 2'd0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 2'd1;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } state_t;

  // Per-instruction control produced by the decoder, consumed in EXEC only.
  typedef struct packed {
    logic                writeEn;
    logic [WSEL_W-1:0]   wdataSel;
    logic [ALU_OP_W-1:0] aluOp;
    logic                inc;
    logic                dec;
    logic                updateZ;
    logic                takeBranch;
    logic                halt;
  } ctrl_t;

  function automatic logic [OPC_W-1:0] opcodeOf(input logic [INSTR_W-1:0] ir);
    return ir[15:12];
  endfunction

  function automatic logic [REG_SEL_W-1:0] rdOf(input logic [INSTR_W-1:0] ir);
    return ir[11:8];
  endfunction

  function automatic logic [REG_SEL_W-1:0] rsOf(input logic [INSTR_W-1:0] ir);
    return ir[7:4];
  endfunction

  function automatic logic [IMM_W-1:0] immOf(input logic [INSTR_W-1:0] ir);
    return ir[7:0];
  endfunction

endpackage

// File: rtl/fetch_control_decode.sv
// Combinational instruction decoder: maps ir and the zero flag to register-file
// control and the relative branch target.
module instr_decode
  import fetch_control_pkg::*;
#(
  parameter int unsigned PC_W = 16
) (
  input  logic [INSTR_W-1:0] ir,
  input  logic               z,
  input  logic [PC_W-1:0]    pc,
  output ctrl_t              ctrl_c,
  output logic [PC_W-1:0]    branchTarget_c
);

  always_comb begin
    ctrl_c = '0;
    case (opcodeOf(ir))
      OP_LDI: begin
        ctrl_c.writeEn  = 1'b1;
        ctrl_c.wdataSel = WSEL_IMM;
      end
      OP_MOV: begin
        ctrl_c.writeEn  = 1'b1;
        ctrl_c.wdataSel = WSEL_B;
      end
      OP_ADD: begin
        ctrl_c.writeEn  = 1'b1;
        ctrl_c.wdataSel = WSEL_ALU;
        ctrl_c.aluOp    = ALU_ADD;
        ctrl_c.updateZ  = 1'b1;
      end
      OP_SUB: begin
        ctrl_c.writeEn  = 1'b1;
        ctrl_c.wdataSel = WSEL_ALU;
        ctrl_c.aluOp    = ALU_SUB;
        ctrl_c.updateZ  = 1'b1;
      end
      OP_INC:  ctrl_c.inc        = 1'b1;
      OP_DEC:  ctrl_c.dec        = 1'b1;
      OP_JMP:  ctrl_c.takeBranch = 1'b1;
      OP_BRZ:  ctrl_c.takeBranch = z;
      OP_HLT:  ctrl_c.halt       = 1'b1;
      default: ;
    endcase
  end

  // pc already points past this instruction, so the offset is from the next one.
  assign branchTarget_c = pc + PC_W'($signed(immOf(ir)));

endmodule

// File: rtl/fetch_control.sv
// Instruction fetch and control sequencer: fetches over req/ack, holds pc, ir
// and the zero flag, and strobes the register file for one EXEC cycle.
module fetch_control
  import fetch_control_pkg::*;
#(
  parameter int unsigned     PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 imem_req,
  output logic [PC_W-1:0]      imem_addr,
  input  logic                 imem_ack,
  input  logic [INSTR_W-1:0]   imem_data,
  output logic [REG_SEL_W-1:0] rf_in_sel,
  output logic [REG_SEL_W-1:0] rf_outa_sel,
  output logic [REG_SEL_W-1:0] rf_outb_sel,
  output logic                 rf_write_en,
  output logic [REG_SEL_W-1:0] rf_inc_sel,
  output logic                 rf_inc,
  output logic                 rf_dec,
  output logic [WSEL_W-1:0]    rf_wdata_sel,
  output logic [IMM_W-1:0]     imm,
  output logic [ALU_OP_W-1:0]  alu_op,
  input  logic                 alu_zero,
  output logic                 halted
);

  state_t               state;
  state_t               nextState;
  logic [PC_W-1:0]      pc;
  logic [PC_W-1:0]      pcNext;
  logic [INSTR_W-1:0]   ir;
  logic [INSTR_W-1:0]   irNext;
  logic                 z;
  logic                 zNext;
  ctrl_t                ctrl;
  logic [PC_W-1:0]      branchTarget;

  instr_decode #(
    .PC_W(PC_W)
  ) u_decode (
    .ir             (ir),
    .z              (z),
    .pc             (pc),
    .ctrl_c         (ctrl),
    .branchTarget_c (branchTarget)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      pc    <= RESET_PC;
      ir    <= '0;
      z     <= 1'b0;
    end else begin
      state <= nextState;
      pc    <= pcNext;
      ir    <= irNext;
      z     <= zNext;
    end
  end

  always_comb begin
    nextState    = state;
    pcNext       = pc;
    irNext       = ir;
    zNext        = z;
    imem_req     = 1'b0;
    rf_write_en  = 1'b0;
    rf_inc       = 1'b0;
    rf_dec       = 1'b0;
    rf_wdata_sel = WSEL_IMM;
    alu_op       = ALU_ADD;
    halted       = 1'b0;
    rf_in_sel    = rdOf(ir);
    rf_outa_sel  = rdOf(ir);
    rf_outb_sel  = rsOf(ir);
    rf_inc_sel   = rdOf(ir);
    imm          = immOf(ir);

    case (state)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          irNext    = imem_data;
          pcNext    = pc + PC_W'(1);
          nextState = EXEC;
        end
      end
      EXEC: begin
        rf_write_en  = ctrl.writeEn;
        rf_inc       = ctrl.inc;
        rf_dec       = ctrl.dec;
        rf_wdata_sel = ctrl.wdataSel;
        alu_op       = ctrl.aluOp;
        if (ctrl.updateZ) begin
          zNext = alu_zero;
        end
        if (ctrl.takeBranch) begin
          pcNext = branchTarget;
        end
        nextState = ctrl.halt ? HALT : FETCH;
      end
      HALT: halted = 1'b1;
      default: nextState = FETCH;
    endcase

    // Reset cycle: abandon any request and suppress strobes immediately.
    if (rst) begin
      imem_req     = 1'b0;
      rf_write_en  = 1'b0;
      rf_inc       = 1'b0;
      rf_dec       = 1'b0;
      rf_wdata_sel = WSEL_IMM;
      alu_op       = ALU_ADD;
      halted       = 1'b0;
      rf_in_sel    = '0;
      rf_outa_sel  = '0;
      rf_outb_sel  = '0;
      rf_inc_sel   = '0;
      imm          = '0;
    end
  end

  assign imem_addr = pc;

endmodule
